stack_sequencer: RTL
====================

Name: stack_sequencer

Overview:
- Sequences the multi-word stack transfers that a decoded instruction requests through its 16-bit push and pop masks (PUSH/POP, PUSHA/POPA, CALL/RET, interrupt entry, RETI).
- Sits between the decode/execute stage and the bus interface unit. Walks the masks one bit at a time, issues one word bus cycle per set bit, and tracks SP.
- Tells the register file which slot is being transferred and when to load it.
- Mask bit meanings: 0 AW, 1 CW, 2 DW, 3 BW, 4 SP, 5 BP_SKIP_SP, 6 BP, 7 IX, 8 IY, 9 DS1, 10 PSW, 11 PS, 12 SS, 13 DS0, 14 PC, 15 OPERAND.

Parameters:
- MASK_W, 16, width of the push/pop masks.
- SP_STEP, 2, bytes added to or subtracted from SP per stack slot.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sequence; ignored while busy=1.
- push_mask  in  16  slots to push; sampled at start.
- pop_mask  in  16  slots to pop; sampled at start.
- sp_in  in  16  SP value at start; sampled at start.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- sp_out  out  16  working SP; final value is valid when done=1.
- push_sp_value  out  16  SP captured at start; the datapath uses it as write data for slot 4.
- bus_req  out  1  word stack bus cycle request (SS segment implied).
- bus_write  out  1  1=push/write, 0=pop/read; valid while bus_req=1.
- bus_addr  out  16  stack offset for the current cycle.
- bus_ack  in  1  bus cycle complete; only meaningful while bus_req=1.
- reg_sel  out  4  slot index (mask bit number) of the current transfer.
- reg_load  out  1  one-cycle pulse on pop ack: load the bus read data into slot reg_sel.

Behaviour:
- Reset: all outputs 0, state IDLE, internal masks cleared. Reset mid-sequence abandons it immediately, with no done pulse.
- States: IDLE, PUSH, POP, SKIP, DONE.
- Start handling: start in IDLE at cycle N latches both masks, sp_in into the working SP, and sp_in into push_sp_value.
  - In cycle N+1 go to PUSH if push_mask≠0, else POP if pop_mask≠0, else DONE.
- Push order: ascending bit index (bit 0 first). Bit 5 in push_mask is ignored.
- Pop order: descending bit index (bit 15 first).
- PUSH:
  - bus_req=1, bus_write=1, bus_addr=SP−SP_STEP (mod 2^16), reg_sel=current lowest remaining bit.
  - On bus_ack: SP←SP−SP_STEP and clear that bit.
  - If the push mask is now empty, next state is POP if the pop mask≠0, else DONE. Otherwise stay in PUSH with the next bit.
- POP:
  - bus_req=1, bus_write=0, bus_addr=SP, reg_sel=current highest remaining bit.
  - On bus_ack: reg_load=1 that cycle, SP←SP+SP_STEP (mod 2^16), clear the bit.
  - If the current bit is 5, enter SKIP instead of issuing a bus cycle.
- SKIP: one cycle, bus_req=0, reg_load=0, SP←SP+SP_STEP, clear bit 5, continue with the next pop bit or go to DONE.
- Bus handshake:
  - bus_req, bus_write, bus_addr and reg_sel stay stable until the cycle bus_ack=1.
  - Ack in the same cycle the request is raised is legal.
  - Back-to-back transfers keep bus_req high continuously: the next slot is presented the cycle after ack.
  - Minimum one cycle per slot.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE. start is accepted in that same DONE cycle.
- busy: 1 in every cycle from N+1 until the DONE cycle, exclusive.
- Both masks non-zero: all pushes complete first, then pops.
- Pop of bit 4 is a normal slot (reg_load with reg_sel=4); the datapath decides its effect.
- Arithmetic: SP wraps modulo 2^16 in both directions.

Test Plan:
- PUSHA: sp_in=0x1000, push_mask=0x01DF, bus_ack tied 1.
  - Expected: 8 writes at 0x0FFE,0x0FFC,…,0x0FF0 with reg_sel 0,1,2,3,4,6,7,8.
  - push_sp_value=0x1000; done at N+9 with sp_out=0x0FF0.
- POPA: sp_in=0x0FF0, pop_mask=0x01EF.
  - Expected: reads at 0x0FF0(8),0x0FF2(7),0x0FF4(6); SKIP cycle with no bus_req; then 0x0FF8(3),0x0FFA(2),0x0FFC(1),0x0FFE(0).
  - 7 reg_load pulses; sp_out=0x1000.
- Interrupt entry then RETI:
  - Entry: push_mask=0x4C00, sp_in=0x0002 → writes 0x0000(10), 0xFFFE(11), 0xFFFC(14); sp_out=0xFFFC (wrap).
  - RETI: pop_mask=0x4C00 from 0xFFFC → reg_sel 14,11,10; sp_out=0x0002.
- Wait states: push_mask=0x0001, bus_ack held low 3 cycles.
  - Expected: bus_req, bus_addr and reg_sel stable all 4 cycles; exactly one SP decrement.
  - start pulses during busy are ignored.
- Empty masks and combined masks:
  - Both masks=0 → done at N+1, no bus_req, sp_out=sp_in.
  - push_mask=0x0001, pop_mask=0x4000, sp_in=0x0100 → write 0x00FE, then read 0x00FE, then sp_out=0x0100.
- Reset mid-POPA (after 2 acks): all outputs 0 immediately, no done; a new start afterwards runs normally.

Source files
------------

// File: rtl/stack_sequencer.sv
// Stack transfer sequencer: walks the push mask (ascending) then the pop mask (descending),
// issuing one word bus cycle per set bit while tracking SP and steering the register file.
module stack_sequencer #(
  parameter int          MASK_W  = 16,
  parameter logic [15:0] SP_STEP = 16'd2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [MASK_W-1:0]         push_mask,
  input  logic [MASK_W-1:0]         pop_mask,
  input  logic [15:0]               sp_in,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               sp_out,
  output logic [15:0]               push_sp_value,
  output logic                      bus_req,
  output logic                      bus_write,
  output logic [15:0]               bus_addr,
  input  logic                      bus_ack,
  output logic [$clog2(MASK_W)-1:0] reg_sel,
  output logic                      reg_load
);

  localparam int SEL_W    = $clog2(MASK_W);
  localparam int SKIP_BIT = 5;
  localparam logic [MASK_W-1:0] BIT0      = {{(MASK_W-1){1'b0}}, 1'b1};
  localparam logic [MASK_W-1:0] SKIP_MASK = BIT0 << SKIP_BIT;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PUSH = 3'd1,
    S_POP  = 3'd2,
    S_SKIP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [MASK_W-1:0] push_q, push_d;
  logic [MASK_W-1:0] pop_q, pop_d;
  logic [15:0]       sp_q, sp_d;
  logic [15:0]       psp_q, psp_d;
  logic [SEL_W-1:0]  push_idx_s;
  logic [SEL_W-1:0]  pop_idx_s;
  logic              accept_s;

  function automatic logic [SEL_W-1:0] lowest_bit(input logic [MASK_W-1:0] m);
    lowest_bit = '0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (m[i]) lowest_bit = SEL_W'(i);
    end
  endfunction

  function automatic logic [SEL_W-1:0] highest_bit(input logic [MASK_W-1:0] m);
    highest_bit = '0;
    for (int i = 0; i < MASK_W; i++) begin
      if (m[i]) highest_bit = SEL_W'(i);
    end
  endfunction

  // A BP_SKIP_SP slot at the head of the pop walk takes the no-bus SKIP path.
  function automatic state_t pop_entry(input logic [MASK_W-1:0] m);
    if (m == '0) begin
      pop_entry = S_DONE;
    end else if (highest_bit(m) == SEL_W'(SKIP_BIT)) begin
      pop_entry = S_SKIP;
    end else begin
      pop_entry = S_POP;
    end
  endfunction

  assign push_idx_s    = lowest_bit(push_q);
  assign pop_idx_s     = highest_bit(pop_q);
  assign accept_s      = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign sp_out        = sp_q;
  assign push_sp_value = psp_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      push_q  <= '0;
      pop_q   <= '0;
      sp_q    <= 16'h0000;
      psp_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      sp_q    <= sp_d;
      psp_q   <= psp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    push_d    = push_q;
    pop_d     = pop_q;
    sp_d      = sp_q;
    psp_d     = psp_q;
    busy      = 1'b0;
    done      = 1'b0;
    bus_req   = 1'b0;
    bus_write = 1'b0;
    bus_addr  = 16'h0000;
    reg_sel   = '0;
    reg_load  = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_PUSH: begin
        busy      = 1'b1;
        bus_req   = 1'b1;
        bus_write = 1'b1;
        bus_addr  = sp_q - SP_STEP;
        reg_sel   = push_idx_s;
        if (bus_ack) begin
          sp_d   = sp_q - SP_STEP;
          push_d = push_q & ~(BIT0 << push_idx_s);
          if (push_d == '0) begin
            state_d = pop_entry(pop_q);
          end else begin
            state_d = S_PUSH;
          end
        end else begin
          state_d = S_PUSH;
        end
      end
      S_POP: begin
        busy    = 1'b1;
        bus_req = 1'b1;
        bus_addr = sp_q;
        reg_sel = pop_idx_s;
        if (bus_ack) begin
          reg_load = 1'b1;
          sp_d     = sp_q + SP_STEP;
          pop_d    = pop_q & ~(BIT0 << pop_idx_s);
          state_d  = pop_entry(pop_d);
        end else begin
          state_d = S_POP;
        end
      end
      S_SKIP: begin
        busy    = 1'b1;
        sp_d    = sp_q + SP_STEP;
        pop_d   = pop_q & ~SKIP_MASK;
        state_d = pop_entry(pop_d);
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // New work is taken in IDLE and also in the DONE cycle itself.
    if (accept_s) begin
      push_d = push_mask & ~SKIP_MASK;
      pop_d  = pop_mask;
      sp_d   = sp_in;
      psp_d  = sp_in;
      if ((push_mask & ~SKIP_MASK) != '0) begin
        state_d = S_PUSH;
      end else begin
        state_d = pop_entry(pop_mask);
      end
    end else begin
      psp_d = psp_d;
    end
  end

endmodule
